// File: rtl/obf_key_pkg.sv
// Shared constants for the camouflaged-cell key loader: cell-select encoding,
// controller state codes and the safe select pattern.
package obf_key_pkg;

  // Two-bit select applied to each camouflaged cell
  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_INV  = 2'b01;
  localparam logic [1:0] SEL_ONE  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // Widest key the safe_pattern helper can describe
  localparam int unsigned MAX_KEY_W = 64;

  // Controller state type and codes
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SHIFT  = 3'd1;
  localparam state_t ST_CHECK  = 3'd2;
  localparam state_t ST_COMMIT = 3'd3;
  localparam state_t ST_LOCKED = 3'd4;

  // Pattern that forces every cell to constant 0; callers cast to their key width
  function automatic logic [MAX_KEY_W-1:0] safe_pattern(input int unsigned key_w);
    logic [MAX_KEY_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < MAX_KEY_W / 2; i++) begin
      if (i < key_w / 2) begin
        p[2*i +: 2] = SEL_ZERO;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/obf_key_loader_shift.sv
// Shadow register, beat counter and running parity of the serial key.
module obf_key_loader_shift
  import obf_key_pkg::*;
#(
  parameter int unsigned KEY_W = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shadow,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             acc_par
);

  // Capture one LSB-first key bit per accepted data beat; restart wipes the partial key
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow  <= '0;
      bit_cnt <= '0;
      acc_par <= 1'b0;
    end else if (restart) begin
      shadow  <= '0;
      bit_cnt <= '0;
      acc_par <= 1'b0;
    end else if (shift_en) begin
      for (int unsigned i = 0; i < KEY_W; i++) begin
        if (bit_cnt == CNT_W'(i)) begin
          shadow[i] <= bit_in;
        end
      end
      bit_cnt <= bit_cnt + CNT_W'(1);
      acc_par <= acc_par ^ bit_in;
    end
  end

endmodule

// File: rtl/obf_key_loader.sv
// Serial key loader for a camouflaged combinational core. Collects the key,
// checks its parity and only then drives the cell-select bus.
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int unsigned NUM_CELLS         = 5,
  parameter int unsigned KEY_W             = 2 * NUM_CELLS,
  parameter bit          LOCK_AFTER_COMMIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             clear_key,
  output logic [KEY_W-1:0] d_out,
  output logic             key_applied,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);
  localparam logic [KEY_W-1:0] SAFE = KEY_W'(safe_pattern(KEY_W));

  state_t state;
  state_t state_n;

  logic             par_reg;
  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] bit_cnt;
  logic             acc_par;

  logic [KEY_W-1:0] d_n;
  logic             applied_n;
  logic             done_n;
  logic             err_n;
  logic             par_n;
  logic             shift_en_c;
  logic             restart_c;

  obf_key_loader_shift #(
    .KEY_W (KEY_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart_c),
    .shift_en (shift_en_c),
    .bit_in   (key_bit),
    .shadow   (shadow),
    .bit_cnt  (bit_cnt),
    .acc_par  (acc_par)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next output values; clear_key overrides everything but reset
  always_comb begin
    state_n    = state;
    d_n        = d_out;
    applied_n  = key_applied;
    done_n     = 1'b0;
    err_n      = err;
    par_n      = par_reg;
    shift_en_c = 1'b0;
    restart_c  = 1'b0;

    if (clear_key) begin
      state_n   = ST_IDLE;
      d_n       = SAFE;
      applied_n = 1'b0;
      restart_c = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state_n   = ST_SHIFT;
            restart_c = 1'b1;
            err_n     = 1'b0;
          end
        end
        ST_SHIFT: begin
          if (load_start) begin
            restart_c = 1'b1;
          end else if (key_valid && key_ready) begin
            if (bit_cnt == CNT_W'(KEY_W)) begin
              par_n   = key_bit;
              state_n = ST_CHECK;
            end else begin
              shift_en_c = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (acc_par == par_reg) begin
            state_n = ST_COMMIT;
          end else begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
        ST_COMMIT: begin
          d_n       = shadow;
          applied_n = 1'b1;
          done_n    = 1'b1;
          state_n   = LOCK_AFTER_COMMIT ? ST_LOCKED : ST_IDLE;
        end
        ST_LOCKED: begin
          if (load_start) begin
            err_n = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Output registers; ready/busy follow the state being entered so they line up with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_out       <= SAFE;
      key_applied <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      key_ready   <= 1'b0;
      busy        <= 1'b0;
      par_reg     <= 1'b0;
    end else begin
      d_out       <= d_n;
      key_applied <= applied_n;
      done        <= done_n;
      err         <= err_n;
      par_reg     <= par_n;
      key_ready   <= (state_n == ST_SHIFT);
      busy        <= (state_n == ST_SHIFT) || (state_n == ST_CHECK) ||
                     (state_n == ST_COMMIT);
    end
  end

endmodule

// File: tb/tb_obf_key_loader.sv
// Self-checking bench for obf_key_loader: a transaction-level reference model
// compared every cycle, plus directed literal expectations.
module tb_obf_key_loader;

  localparam int unsigned KEY_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_start;
  logic             key_bit;
  logic             key_valid;
  logic             clear_key;
  logic             key_ready;
  logic [KEY_W-1:0] d_out;
  logic             key_applied;
  logic             busy;
  logic             done;
  logic             err;

  obf_key_loader #(
    .NUM_CELLS         (5),
    .LOCK_AFTER_COMMIT (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .key_bit     (key_bit),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .clear_key   (clear_key),
    .d_out       (d_out),
    .key_applied (key_applied),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cyc = -1;

  // Reference model: a load is a list of received bits; once KEY_W+1 bits
  // arrive the result appears two cycles later (check, then commit).
  logic [KEY_W-1:0] m_d;
  logic [KEY_W-1:0] m_key;
  bit m_app, m_done, m_err, m_loading, m_locked, m_valid, m_par_ok;
  int m_pipe;
  bit m_bits[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_d = '1; m_app = 1'b0; m_err = 1'b0;
      m_loading = 1'b0; m_locked = 1'b0; m_pipe = 0;
      m_bits.delete();
    end else if (clear_key) begin
      m_d = '1; m_app = 1'b0;
      m_loading = 1'b0; m_locked = 1'b0; m_pipe = 0;
      m_bits.delete();
    end else if (m_pipe == 2) begin
      if (m_par_ok) m_pipe = 1;
      else begin
        m_err = 1'b1; m_pipe = 0; m_loading = 1'b0;
      end
    end else if (m_pipe == 1) begin
      m_d = m_key; m_app = 1'b1; m_done = 1'b1;
      m_pipe = 0; m_loading = 1'b0; m_locked = 1'b1;
    end else if (m_locked) begin
      if (load_start) m_err = 1'b1;
    end else if (!m_loading) begin
      if (load_start) begin
        m_loading = 1'b1; m_err = 1'b0; m_bits.delete();
      end
    end else if (load_start) begin
      m_bits.delete();
    end else if (key_valid) begin
      if (m_bits.size() < KEY_W) m_bits.push_back(key_bit);
      else begin
        for (int i = 0; i < KEY_W; i++) m_key[i] = m_bits[i];
        m_par_ok = ((^m_key) == key_bit);
        m_pipe = 2;
      end
    end
  end

  // Compare DUT against the model away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("d_out", 32'(d_out), 32'(m_d));
      chk("key_applied", 32'(key_applied), 32'(m_app));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_loading));
      chk("key_ready", 32'(key_ready), 32'(m_loading && (m_pipe == 0)));
      if (done) done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(output int t0);
    load_start = 1'b1;
    t0 = cyc;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_key = 1'b1;
    tick();
    clear_key = 1'b0;
    tick();
  endtask

  task automatic send_key(input logic [KEY_W-1:0] key, input logic par, input bit gap,
                          output int stalls);
    stalls = 0;
    for (int i = 0; i <= KEY_W; i++) begin
      if (gap && i > 0) begin
        key_valid = 1'b0;
        tick();
        stalls++;
      end
      key_valid = 1'b1;
      key_bit = (i == KEY_W) ? par : key[i];
      tick();
    end
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int t0, input int exp_lat);
    for (int n = 0; n < 60; n++) begin
      if (done_cyc >= 0) break;
      tick();
    end
    chk(name, 32'(done_cyc - t0), 32'(exp_lat));
  endtask

  task automatic full_load(input string name, input logic [KEY_W-1:0] key, input logic par,
                           input bit gap, input int exp_lat);
    int t0;
    int st;
    done_cyc = -1;
    pulse_load(t0);
    send_key(key, par, gap, st);
    wait_done(name, t0, exp_lat);
    tick();
  endtask

  initial begin
    int t0;
    int st;
    rst_n = 1'b0; load_start = 1'b0; key_bit = 1'b0; key_valid = 1'b0; clear_key = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (5) tick();
    chk("idle_d_out", 32'(d_out), 32'h3FF);
    chk("idle_applied", 32'(key_applied), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // 2: all-pass key, gapless, done at t+14
    full_load("lat_zero_key", 10'h000, 1'b0, 1'b0, 14);
    chk("zero_key_d_out", 32'(d_out), 32'h000);
    chk("zero_key_applied", 32'(key_applied), 32'h1);

    // 3: wrong parity leaves the safe pattern
    pulse_clear();
    pulse_load(t0);
    send_key(10'h1B1, 1'b0, 1'b0, st);
    repeat (4) tick();
    chk("badpar_err", 32'(err), 32'h1);
    chk("badpar_d_out", 32'(d_out), 32'h3FF);
    chk("badpar_applied", 32'(key_applied), 32'h0);

    // 4: gapless then gapped load of the same key
    full_load("lat_gapless", 10'h1B1, 1'b1, 1'b0, 14);
    chk("gapless_d_out", 32'(d_out), 32'h1B1);
    chk("gapless_err_cleared", 32'(err), 32'h0);
    pulse_clear();
    full_load("lat_gapped", 10'h1B1, 1'b1, 1'b1, 24);
    chk("gapped_d_out", 32'(d_out), 32'h1B1);

    // 5: reload attempt while locked, then clear and reload
    pulse_load(t0);
    tick();
    chk("locked_err", 32'(err), 32'h1);
    chk("locked_d_out", 32'(d_out), 32'h1B1);
    chk("locked_busy", 32'(busy), 32'h0);
    pulse_clear();
    chk("cleared_d_out", 32'(d_out), 32'h3FF);
    chk("cleared_applied", 32'(key_applied), 32'h0);
    chk("clear_keeps_err", 32'(err), 32'h1);
    full_load("lat_155", 10'h155, 1'b1, 1'b0, 14);
    chk("key155_d_out", 32'(d_out), 32'h155);

    // 6a: reset after 4 beats, then a clean load with no residue
    pulse_clear();
    pulse_load(t0);
    key_valid = 1'b1; key_bit = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; key_valid = 1'b0;
    tick();
    chk("rst_mid_d_out", 32'(d_out), 32'h3FF);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    full_load("lat_2aa", 10'h2AA, 1'b1, 1'b0, 14);
    chk("key2aa_d_out", 32'(d_out), 32'h2AA);

    // 6b: clear during SHIFT
    pulse_clear();
    pulse_load(t0);
    key_valid = 1'b1; key_bit = 1'b0;
    repeat (3) tick();
    key_valid = 1'b0;
    pulse_clear();
    chk("clr_shift_d_out", 32'(d_out), 32'h3FF);
    chk("clr_shift_busy", 32'(busy), 32'h0);
    chk("clr_shift_ready", 32'(key_ready), 32'h0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
